// File: rtl/sr_bridge_receiver.sv
// Slave-side receiver for the bridge serial register-load protocol.
// Oversamples SCLK/MOSI/SEL/DONE_IN on CLK, deserialises a dynamic word
// followed by a static word (MSB first), and flags protocol errors.
module sr_bridge_receiver #(
  parameter int SIZESRDYN      = 16,
  parameter int SIZESRSTAT     = 88,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  SEL,
  input  logic                  DONE_IN,
  output logic [SIZESRDYN-1:0]  dyn_reg,
  output logic [SIZESRSTAT-1:0] stat_reg,
  output logic                  dyn_valid,
  output logic                  stat_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  cfg_ready
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DYN       = 2'd1,
    ST_STAT      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] sel_sync_q;
  logic [SYNC_STAGES-1:0] done_sync_q;
  logic                   sclk_prev_q;

  state_t                  state_q;
  logic [6:0]              cnt_q;
  logic [IDLE_W-1:0]       idle_cnt_q;
  logic [SIZESRSTAT-1:0]   shift_q;
  logic [SIZESRDYN-1:0]    dyn_reg_q;
  logic [SIZESRSTAT-1:0]   stat_reg_q;
  logic                    dyn_valid_q;
  logic                    stat_valid_q;
  logic                    busy_q;
  logic                    frame_err_q;
  logic                    cfg_ready_q;

  logic                    sclk_s;
  logic                    mosi_s;
  logic                    sel_s;
  logic                    done_s;
  logic                    sclk_rise_s;
  logic                    timeout_s;
  logic [SIZESRSTAT-1:0]   shift_nxt_s;

  // Equal-depth synchronisers keep MOSI/SEL aligned with the SCLK edge they belong to.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sel_sync_q  <= '0;
      done_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], SEL};
      done_sync_q <= {done_sync_q[SYNC_STAGES-2:0], DONE_IN};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sel_s       = sel_sync_q[SYNC_STAGES-1];
  assign done_s      = done_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign timeout_s   = (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES));
  assign shift_nxt_s = {shift_q[SIZESRSTAT-2:0], mosi_s};

  // Frame state machine: shifting, word capture, error/timeout handling, registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 7'd0;
      idle_cnt_q   <= '0;
      shift_q      <= '0;
      dyn_reg_q    <= '0;
      stat_reg_q   <= '0;
      dyn_valid_q  <= 1'b0;
      stat_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      cfg_ready_q  <= 1'b0;
    end else begin
      dyn_valid_q  <= 1'b0;
      stat_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          idle_cnt_q <= '0;
          if (sclk_rise_s) begin
            if (sel_s) begin
              shift_q     <= shift_nxt_s;
              cnt_q       <= 7'd1;
              cfg_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= ST_DYN;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        ST_DYN: begin
          if (sclk_rise_s) begin
            idle_cnt_q <= '0;
            if (sel_s) begin
              shift_q <= shift_nxt_s;
              if (cnt_q == 7'(SIZESRDYN - 1)) begin
                dyn_reg_q   <= shift_nxt_s[SIZESRDYN-1:0];
                dyn_valid_q <= 1'b1;
                cnt_q       <= 7'd0;
                state_q     <= ST_STAT;
              end else begin
                cnt_q <= cnt_q + 7'd1;
              end
            end else begin
              frame_err_q <= 1'b1;
              cnt_q       <= 7'd0;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end else if (timeout_s) begin
            frame_err_q <= 1'b1;
            cnt_q       <= 7'd0;
            idle_cnt_q  <= '0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
          end
        end
        ST_STAT: begin
          if (sclk_rise_s) begin
            idle_cnt_q <= '0;
            if (!sel_s) begin
              shift_q <= shift_nxt_s;
              if (cnt_q == 7'(SIZESRSTAT - 1)) begin
                stat_reg_q   <= shift_nxt_s;
                stat_valid_q <= 1'b1;
                cnt_q        <= 7'd0;
                busy_q       <= 1'b0;
                state_q      <= ST_WAIT_DONE;
              end else begin
                cnt_q <= cnt_q + 7'd1;
              end
            end else begin
              frame_err_q <= 1'b1;
              cnt_q       <= 7'd0;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end else if (timeout_s) begin
            frame_err_q <= 1'b1;
            cnt_q       <= 7'd0;
            idle_cnt_q  <= '0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          idle_cnt_q <= '0;
          if (done_s) begin
            cfg_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (sclk_rise_s) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT_DONE;
          end
        end
        default: begin
          cnt_q      <= 7'd0;
          idle_cnt_q <= '0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign dyn_reg    = dyn_reg_q;
  assign stat_reg   = stat_reg_q;
  assign dyn_valid  = dyn_valid_q;
  assign stat_valid = stat_valid_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign cfg_ready  = cfg_ready_q;

endmodule

// File: tb/tb_sr_bridge_receiver.sv
// Self-checking bench for sr_bridge_receiver: table of frames plus hand-written
// corner sequences; valid pulses are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_sr_bridge_receiver;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         SCLK = 1'b0;
  logic         MOSI = 1'b0;
  logic         SEL = 1'b0;
  logic         DONE_IN = 1'b0;
  logic [15:0]  dyn_reg;
  logic [87:0]  stat_reg;
  logic         dyn_valid;
  logic         stat_valid;
  logic         busy;
  logic         frame_err;
  logic         cfg_ready;

  int checks = 0;
  int failures = 0;

  logic [15:0] dyn_exp_q[$];
  logic [87:0] stat_exp_q[$];

  logic [15:0] m_dyn;
  logic [87:0] m_stat;
  logic        m_err;
  logic        m_cfg;

  typedef struct {
    logic [15:0] dyn_in;
    logic [87:0] stat_in;
    int          ratio;
    logic [15:0] exp_dyn;
    logic [87:0] exp_stat;
  } frame_t;
  frame_t tbl[4];

  sr_bridge_receiver dut (
    .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .MOSI(MOSI), .SEL(SEL), .DONE_IN(DONE_IN),
    .dyn_reg(dyn_reg), .stat_reg(stat_reg), .dyn_valid(dyn_valid), .stat_valid(stat_valid),
    .busy(busy), .frame_err(frame_err), .cfg_ready(cfg_ready)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every valid pulse must match the oldest expected word of its type.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (dyn_valid) begin
        checks++;
        if (dyn_exp_q.size() == 0) begin
          failures++;
          $display("FAIL dyn_valid_unexpected got dyn_reg=%h, no word expected", dyn_reg);
        end else begin
          logic [15:0] e;
          e = dyn_exp_q.pop_front();
          if (dyn_reg !== e) begin
            failures++;
            $display("FAIL dyn_word got=%h exp=%h", dyn_reg, e);
          end
        end
      end
      if (stat_valid) begin
        checks++;
        if (stat_exp_q.size() == 0) begin
          failures++;
          $display("FAIL stat_valid_unexpected got stat_reg=%h, no word expected", stat_reg);
        end else begin
          logic [87:0] e;
          e = stat_exp_q.pop_front();
          if (stat_reg !== e) begin
            failures++;
            $display("FAIL stat_word got=%h exp=%h", stat_reg, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_model(input string tag);
    check({tag, ":dyn_reg"},   {72'd0, dyn_reg}, {72'd0, m_dyn});
    check({tag, ":stat_reg"},  stat_reg, m_stat);
    check({tag, ":frame_err"}, {87'd0, frame_err}, {87'd0, m_err});
    check({tag, ":cfg_ready"}, {87'd0, cfg_ready}, {87'd0, m_cfg});
    check({tag, ":busy"},      {87'd0, busy}, 88'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":dyn_reg0"},  {72'd0, dyn_reg}, 88'd0);
    check({tag, ":stat_reg0"}, stat_reg, 88'd0);
    check({tag, ":flags0"},
          {83'd0, dyn_valid, stat_valid, busy, frame_err, cfg_ready}, 88'd0);
  endtask

  // Assert reset, confirm outputs clear while it is held, then release.
  task automatic do_reset(input string tag);
    #3;
    RST_N = 1'b0;
    SCLK = 1'b0;
    DONE_IN = 1'b0;
    dyn_exp_q.delete();
    stat_exp_q.delete();
    m_dyn = '0; m_stat = '0; m_err = 1'b0; m_cfg = 1'b0;
    wait_clk(2);
    check_all_zero(tag);
    RST_N = 1'b1;
    wait_clk(3);
  endtask

  // Send nbits of a width-bit word MSB first; SCLK period = ratio CLK periods.
  task automatic send_bits(input logic sel, input logic [87:0] word, input int width,
                           input int nbits, input int ratio);
    for (int i = 0; i < nbits; i++) begin
      SEL  = sel;
      MOSI = word[width-1-i];
      #(ratio * 5);
      SCLK = 1'b1;
      #(ratio * 5);
      SCLK = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] d, input logic [87:0] s,
                           input int ratio);
    DONE_IN = 1'b0;
    #($urandom_range(1, 9));
    dyn_exp_q.push_back(d);
    m_dyn = d;
    m_cfg = 1'b0;
    send_bits(1'b1, {72'd0, d}, 16, 16, ratio);
    stat_exp_q.push_back(s);
    m_stat = s;
    send_bits(1'b0, s, 88, 88, ratio);
    wait_clk(10);
    check({tag, ":cfg_before_done"}, {87'd0, cfg_ready}, 88'd0);
    DONE_IN = 1'b1;
    wait_clk(8);
    m_cfg = 1'b1;
    check_model(tag);
  endtask

  initial begin
    logic [15:0] nd;
    logic [87:0] ns;
    nd = 16'hABC6;
    ns = 88'h123456789ABCDEF1234567;

    tbl[0] = '{nd, ns, 8, nd, ns};
    tbl[1] = '{nd, ns, 37, nd, ns};
    tbl[2].dyn_in  = 16'($urandom);
    tbl[2].stat_in = {24'($urandom), $urandom, $urandom};
    tbl[2].ratio   = 8;
    tbl[3].dyn_in  = 16'($urandom);
    tbl[3].stat_in = {24'($urandom), $urandom, $urandom};
    tbl[3].ratio   = 37;
    for (int k = 2; k < 4; k++) begin
      tbl[k].exp_dyn  = tbl[k].dyn_in;
      tbl[k].exp_stat = tbl[k].stat_in;
    end

    do_reset("reset");

    // Table of complete frames at both clock ratios with random phase.
    for (int k = 0; k < 4; k++) begin
      run_frame($sformatf("frame%0d", k), tbl[k].dyn_in, tbl[k].stat_in, tbl[k].ratio);
      check($sformatf("frame%0d:tbl_dyn", k), {72'd0, dyn_reg}, {72'd0, tbl[k].exp_dyn});
      check($sformatf("frame%0d:tbl_stat", k), stat_reg, tbl[k].exp_stat);
    end

    // Spurious SEL=0 edge in IDLE: error only, registers and cfg_ready kept.
    DONE_IN = 1'b0;
    send_bits(1'b0, 88'hFF, 88, 1, 8);
    wait_clk(8);
    m_err = 1'b1;
    check_model("spurious");

    // Short dynamic word aborted by a SEL=0 edge.
    do_reset("reset_short");
    send_bits(1'b1, {72'd0, nd}, 16, 10, 8);
    wait_clk(4);
    check("short:busy_mid", {87'd0, busy}, 88'd1);
    send_bits(1'b0, 88'd0, 88, 1, 8);
    wait_clk(8);
    m_err = 1'b1;
    check_model("short");
    run_frame("after_short", nd, ns, 8);

    // Timeout after 40 static bits.
    do_reset("reset_timeout");
    dyn_exp_q.push_back(nd);
    m_dyn = nd;
    send_bits(1'b1, {72'd0, nd}, 16, 16, 8);
    send_bits(1'b0, ns, 88, 40, 8);
    wait_clk(10);
    check("timeout:busy_before", {87'd0, busy}, 88'd1);
    wait_clk(4200);
    m_err = 1'b1;
    check_model("timeout");

    // Reset in the middle of the static word, then a fresh frame.
    do_reset("reset_pre_mid");
    dyn_exp_q.push_back(nd);
    send_bits(1'b1, {72'd0, nd}, 16, 16, 8);
    send_bits(1'b0, ns, 88, 50, 8);
    wait_clk(2);
    check("midstat:busy", {87'd0, busy}, 88'd1);
    do_reset("reset_mid");
    run_frame("after_reset", nd, ns, 37);

    check("sb:dyn_left",  88'(dyn_exp_q.size()), 88'd0);
    check("sb:stat_left", 88'(stat_exp_q.size()), 88'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_bridge_receiver.md
Name: sr_bridge_receiver

Overview:
- Slave-side receiver for the bridge's serial register-load protocol.
- Deserialises a 16-bit dynamic word followed by an 88-bit static word from MOSI, qualified by SEL and a gated serial clock.
- The serial inputs are asynchronous to CLK; the block oversamples them on the fast CLK.
- Presents the captured words with valid pulses, and raises cfg_ready when the transmitter signals completion.

Parameters:
- SIZESRDYN, 16, dynamic word length (bits).
- SIZESRSTAT, 88, static word length (bits).
- SYNC_STAGES, 2, synchroniser depth on SCLK/MOSI/SEL/DONE_IN (min 2).
- TIMEOUT_CYCLES, 4096, CLK cycles without an SCLK rising edge inside a frame before the frame is aborted.

Ports:
- CLK  in  1  fast system clock; f_CLK >= 8x f_SCLK.
- RST_N  in  1  asynchronous active-low reset.
- SCLK  in  1  gated serial clock from the transmitter; toggles only during a frame.
- MOSI  in  1  serial data, MSB first, stable around SCLK rising edges.
- SEL  in  1  register select: 1 = dynamic word, 0 = static word; changes together with MOSI.
- DONE_IN  in  1  transmitter completion flag, level, sticky high.
- dyn_reg  out  SIZESRDYN  last complete dynamic word.
- stat_reg  out  SIZESRSTAT  last complete static word.
- dyn_valid  out  1  one-CLK pulse when dyn_reg updates.
- stat_valid  out  1  one-CLK pulse when stat_reg updates.
- busy  out  1  high in DYN or STAT.
- frame_err  out  1  sticky protocol error; cleared only by reset.
- cfg_ready  out  1  both words captured and DONE_IN seen.

Behaviour:
- One clock, CLK; asynchronous active-low reset RST_N. All outputs are registered.
- Reset values: dyn_reg = 0, stat_reg = 0, all 1-bit outputs = 0, state = IDLE, counters = 0.
- Synchronisation:
  - SCLK, MOSI, SEL and DONE_IN pass through SYNC_STAGES flops, all of equal depth.
  - sclk_rise = synced SCLK high AND its previous value low.
  - MOSI and SEL are sampled from the synced copies in the same CLK cycle as sclk_rise.
- Shifting: MSB first. The shift register moves left and inserts the new bit at the LSB. After N bits, bit N-1 holds the first bit received.
- Bit counter: 7 bits wide; counts sampled bits within the current word.
- State machine (IDLE, DYN, STAT, WAIT_DONE):
  - IDLE, sclk_rise & SEL=1: shift the bit, cnt = 1, clear cfg_ready, go to DYN.
  - IDLE, sclk_rise & SEL=0: set frame_err, stay in IDLE.
  - DYN, sclk_rise & SEL=1: shift, cnt+1.
    - On the SIZESRDYN-th bit: the next cycle dyn_reg gets the full shifter value and dyn_valid = 1 for 1 cycle; cnt = 0; go to STAT.
  - DYN, sclk_rise & SEL=0 before the word is complete: set frame_err, discard the partial word, go to IDLE.
  - STAT, sclk_rise & SEL=0: shift, cnt+1.
    - On the SIZESRSTAT-th bit: stat_reg updates and stat_valid pulses the next cycle; go to WAIT_DONE.
  - STAT, sclk_rise & SEL=1: set frame_err, go to IDLE; stat_reg is not updated.
  - WAIT_DONE, synced DONE_IN = 1: set cfg_ready = 1, go to IDLE.
  - WAIT_DONE, sclk_rise: set frame_err, go to IDLE; cfg_ready stays 0.
- Latency: the valid pulse is asserted 1 CLK after the sclk_rise of the final bit, i.e. SYNC_STAGES+2 CLK after the raw SCLK edge.
- Timeout:
  - An idle counter runs in DYN and STAT and resets on every sclk_rise.
  - Reaching TIMEOUT_CYCLES sets frame_err and returns to IDLE; partial data is discarded.
  - The counter saturates and does not wrap.
- Partial words never reach dyn_reg or stat_reg. A valid register keeps its value until the next complete word of the same type.
- cfg_ready remains high in IDLE until the next frame start. frame_err does not block later frames.
- DONE_IN high in IDLE, DYN or STAT is ignored.
- Reset mid-frame: all state, outputs and counters return to their reset values immediately (asynchronously).

Test Plan:
- Nominal frame: SEL=1 with 16 bits of 16'hABC6, then SEL=0 with 88 bits of 88'h123456789ABCDEF1234567, then DONE_IN=1 -> dyn_valid pulse with dyn_reg = ABC6; stat_valid pulse with stat_reg = 123456789ABCDEF1234567; cfg_ready = 1; frame_err = 0; exactly one pulse of each valid.
- Short dynamic word: 10 SEL=1 bits, then SEL=0 edge -> frame_err = 1, dyn_reg stays 0, no dyn_valid, state = IDLE; a following nominal frame still loads ABC6 / static correctly.
- Timeout: stop SCLK after 40 static bits for > TIMEOUT_CYCLES -> frame_err = 1, busy = 0, stat_reg unchanged, no stat_valid.
- Async SCLK ratio sweep: f_CLK/f_SCLK = 8 and 37 with random phase -> bit-exact capture of both words in every run.
- Reset mid-STAT at bit 50 -> all outputs 0 within the reset assertion; a fresh frame after release captures correctly.
- Spurious edge: SCLK pulse with SEL=0 in IDLE -> frame_err = 1, no valids, dyn_reg and stat_reg unchanged.
